// File: rtl/ram_cmd_sequencer.sv
// ram_cmd_sequencer: accepts LOAD (single RAM write) and SCAN (burst of
// address reads) commands, tracks outstanding reads with a latency-matched
// tag pipeline and buffers returned data in a small response FIFO.
// Issue is credit-limited so the FIFO can never overflow.
// Optional feature: define RAM_SEQ_PARITY_EN to add o_rsp_par, the XOR of
// the stored response byte and bit, captured per FIFO entry at push.
module ram_cmd_sequencer #(
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_op,
  input  logic [63:0] i_cmd_data,
  input  logic [5:0]  i_cmd_start,
  input  logic [5:0]  i_cmd_len,
  output logic [5:0]  o_ram_add,
  output logic [63:0] o_ram_data,
  output logic        o_ram_wr,
  input  logic [7:0]  i_ram_byte,
  input  logic        i_ram_bit,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [7:0]  o_rsp_byte,
  output logic        o_rsp_bit,
  output logic        o_rsp_last,
`ifdef RAM_SEQ_PARITY_EN
  output logic        o_rsp_par,
`endif
  output logic        o_busy
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_DRAIN} state_t;

  state_t            r_state;
  logic [5:0]        r_ram_add;
  logic [63:0]       r_ram_data;
  logic              r_ram_wr;
  logic [5:0]        r_cnt;
  logic [5:0]        r_len;

  logic [RD_LAT-1:0] r_tag_vld;
  logic [RD_LAT-1:0] r_tag_last;
  logic [CW-1:0]     r_inflight;

  logic [7:0]        r_fifo_byte [RSP_DEPTH];
  logic [RSP_DEPTH-1:0] r_fifo_bit;
  logic [RSP_DEPTH-1:0] r_fifo_last;
`ifdef RAM_SEQ_PARITY_EN
  logic [RSP_DEPTH-1:0] r_fifo_par;
`endif
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_fifo_cnt;

  logic              w_credit_ok;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic [RD_LAT:0]   w_vld_chain;
  logic [RD_LAT:0]   w_last_chain;

  // A read may only be issued while reads in flight plus buffered responses
  // leave room in the FIFO; the tag leaving the pipeline marks returned data.
  assign w_credit_ok  = ({1'b0, r_inflight} + {1'b0, r_fifo_cnt}) < (CW+1)'(RSP_DEPTH);
  assign w_issue      = (r_state == S_ISSUE) && w_credit_ok;
  assign w_issue_last = w_issue && (r_cnt == r_len);
  assign w_push       = r_tag_vld[RD_LAT-1];
  assign w_empty      = (r_fifo_cnt == '0);
  assign w_pop        = !w_empty && i_rsp_ready;
  assign w_vld_chain  = {r_tag_vld, w_issue};
  assign w_last_chain = {r_tag_last, w_issue_last};

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_ram_add    = r_ram_add;
  assign o_ram_data   = r_ram_data;
  assign o_ram_wr     = r_ram_wr;
  assign o_busy       = (r_state != S_IDLE) || (r_inflight != '0);
  assign o_rsp_valid  = !w_empty;
  assign o_rsp_byte   = w_empty ? 8'h00 : r_fifo_byte[r_rd_ptr];
  assign o_rsp_bit    = w_empty ? 1'b0  : r_fifo_bit[r_rd_ptr];
  assign o_rsp_last   = w_empty ? 1'b0  : r_fifo_last[r_rd_ptr];
`ifdef RAM_SEQ_PARITY_EN
  assign o_rsp_par    = w_empty ? 1'b0  : r_fifo_par[r_rd_ptr];
`endif

  // Command FSM: accepts commands in IDLE, pulses the write for LOAD and
  // walks the SCAN address range (wrapping mod 64) under credit control.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_ram_add  <= '0;
      r_ram_data <= '0;
      r_ram_wr   <= 1'b0;
      r_cnt      <= '0;
      r_len      <= '0;
    end else begin
      r_ram_wr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_op) begin
              r_state   <= S_ISSUE;
              r_ram_add <= i_cmd_start;
              r_len     <= i_cmd_len;
              r_cnt     <= '0;
            end else begin
              r_state    <= S_LOAD;
              r_ram_data <= i_cmd_data;
              r_ram_wr   <= 1'b1;
            end
          end
        end
        S_LOAD: r_state <= S_IDLE;
        S_ISSUE: begin
          if (w_issue) begin
            r_cnt <= r_cnt + 6'd1;
            if (w_issue_last) r_state <= S_DRAIN;
            else              r_ram_add <= r_ram_add + 6'd1;
          end
        end
        S_DRAIN: if (r_inflight == '0) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag pipeline aligned to the RAM read latency, plus in-flight read count.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tag_vld  <= '0;
      r_tag_last <= '0;
      r_inflight <= '0;
    end else begin
      r_tag_vld  <= w_vld_chain[RD_LAT-1:0];
      r_tag_last <= w_last_chain[RD_LAT-1:0];
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
    end
  end

  // Response FIFO: captures returned data when a tag exits, pops on handshake.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_fifo_byte[r_wr_ptr] <= i_ram_byte;
        r_fifo_bit[r_wr_ptr]  <= i_ram_bit;
        r_fifo_last[r_wr_ptr] <= r_tag_last[RD_LAT-1];
`ifdef RAM_SEQ_PARITY_EN
        r_fifo_par[r_wr_ptr]  <= ^{i_ram_byte, i_ram_bit};
`endif
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_fifo_cnt <= r_fifo_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_ram_cmd_sequencer.sv
// Testbench for ram_cmd_sequencer. A behavioural RAM controller returns
// data RD_LAT cycles after each address; every SCAN command pre-computes its
// expected response list (address order, last flag on the final one) into a
// queue that a response monitor consumes.
module tb_ram_cmd_sequencer;

  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 4;

  typedef struct packed {
    logic [7:0] b;
    logic       bt;
    logic       last;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_op = 1'b0;
  logic [63:0] cmd_data = '0;
  logic [5:0]  cmd_start = '0;
  logic [5:0]  cmd_len = '0;
  logic        cmd_ready;
  logic [5:0]  ram_add;
  logic [63:0] ram_data;
  logic        ram_wr;
  logic [7:0]  ram_byte;
  logic        ram_bit;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_byte;
  logic        rsp_bit;
  logic        rsp_last;
  logic        busy;
`ifdef RAM_SEQ_PARITY_EN
  logic        rsp_par;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  memByte [64];
  logic        memBit [64];
  logic [5:0]  addrHist [RD_LAT];
  rsp_t        expQ [$];
  rsp_t        monEntry;
  logic        randomReady = 1'b0;
  logic [63:0] lastLoad = '0;

  ram_cmd_sequencer #(.RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cmd_valid (cmd_valid),
    .o_cmd_ready (cmd_ready),
    .i_cmd_op    (cmd_op),
    .i_cmd_data  (cmd_data),
    .i_cmd_start (cmd_start),
    .i_cmd_len   (cmd_len),
    .o_ram_add   (ram_add),
    .o_ram_data  (ram_data),
    .o_ram_wr    (ram_wr),
    .i_ram_byte  (ram_byte),
    .i_ram_bit   (ram_bit),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_byte  (rsp_byte),
    .o_rsp_bit   (rsp_bit),
    .o_rsp_last  (rsp_last),
`ifdef RAM_SEQ_PARITY_EN
    .o_rsp_par   (rsp_par),
`endif
    .o_busy      (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // RAM controller model: the address seen in a cycle is answered RD_LAT cycles later.
  always @(posedge clk) begin
    addrHist[0] <= ram_add;
    for (int k = 1; k < RD_LAT; k++) addrHist[k] <= addrHist[k-1];
  end
  assign ram_byte = memByte[addrHist[RD_LAT-1]];
  assign ram_bit  = memBit[addrHist[RD_LAT-1]];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change 1 ns after the rising edge, outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
    if (randomReady) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic randomizeMem();
    for (int i = 0; i < 64; i++) begin
      memByte[i] = 8'($urandom);
      memBit[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  // Offer one command, wait for acceptance, and record the expected SCAN responses.
  task automatic applyStimulus(input logic op, input logic [63:0] data,
                               input logic [5:0] start, input logic [5:0] len);
    int   w;
    rsp_t e;
    logic [5:0] a;
    w = 0;
    while (!cmd_ready && w < 500) begin
      step();
      w++;
    end
    checkOutput("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_start = start;
    cmd_len   = len;
    if (op) begin
      for (int i = 0; i <= int'(len); i++) begin
        a      = start + 6'(i);
        e.b    = memByte[a];
        e.bt   = memBit[a];
        e.last = (i == int'(len));
        expQ.push_back(e);
      end
    end
    step();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until the scan has fully drained and every response was consumed.
  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((busy || rsp_valid || expQ.size() != 0) && n < budget) begin
      step();
      n++;
    end
    checkOutput("scan_drain_left", 64'(expQ.size()), 64'd0);
    checkOutput("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    checkOutput({tag, "_ram_add"},   64'(ram_add),   64'd0);
    checkOutput({tag, "_ram_data"},  ram_data,       64'd0);
    checkOutput({tag, "_ram_wr"},    64'(ram_wr),    64'd0);
    checkOutput({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    checkOutput({tag, "_rsp_byte"},  64'(rsp_byte),  64'd0);
    checkOutput({tag, "_rsp_bit"},   64'(rsp_bit),   64'd0);
    checkOutput({tag, "_rsp_last"},  64'(rsp_last),  64'd0);
    checkOutput({tag, "_busy"},      64'(busy),      64'd0);
  endtask

  // Response monitor: every accepted response must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        monEntry = expQ.pop_front();
        checkOutput("rsp_byte", 64'(rsp_byte), 64'(monEntry.b));
        checkOutput("rsp_bit",  64'(rsp_bit),  64'(monEntry.bt));
        checkOutput("rsp_last", 64'(rsp_last), 64'(monEntry.last));
`ifdef RAM_SEQ_PARITY_EN
        checkOutput("rsp_par",  64'(rsp_par),  64'(^{monEntry.b, monEntry.bt}));
`endif
      end
    end
  end

  // Hard stop in case something deadlocks outside the bounded waits.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence of steps with randomized memory contents and scan parameters.
  initial begin
    logic [63:0] d;
    int          n;

    randomizeMem();
    rst = 1'b0;
    repeat (3) step();
    checkResetValues("por");
    rst = 1'b1;
    step();

    // LOAD of the reference word: one-cycle write strobe, then ready again.
    applyStimulus(1'b0, 64'hA5A5_0000_FFFF_1234, 6'd0, 6'd0);
    checkOutput("load_wr_high",   64'(ram_wr),    64'd1);
    checkOutput("load_data",      ram_data,       64'hA5A5_0000_FFFF_1234);
    checkOutput("load_not_ready", 64'(cmd_ready), 64'd0);
    step();
    checkOutput("load_wr_low",    64'(ram_wr),    64'd0);
    checkOutput("load_ready",     64'(cmd_ready), 64'd1);

    // A few random LOAD words.
    repeat (3) begin
      d = {$urandom, $urandom};
      applyStimulus(1'b0, d, 6'd0, 6'd0);
      checkOutput("rload_wr",   64'(ram_wr), 64'd1);
      checkOutput("rload_data", ram_data,    d);
      step();
      checkOutput("rload_wr_low", 64'(ram_wr), 64'd0);
      lastLoad = d;
    end

    // SCAN across the 63 -> 0 wrap with the consumer always ready.
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 64'd0, 6'd62, 6'd3);
    checkOutput("wrap_add0", 64'(ram_add), 64'd62);
    checkOutput("wrap_busy", 64'(busy),    64'd1);
    step();
    checkOutput("wrap_add1", 64'(ram_add), 64'd63);
    step();
    checkOutput("wrap_add2", 64'(ram_add), 64'd0);
    step();
    checkOutput("wrap_add3", 64'(ram_add), 64'd1);
    waitIdle(200);

    // Full 64-read SCAN with the consumer stalled: only RSP_DEPTH reads issue.
    rsp_ready = 1'b0;
    randomizeMem();
    applyStimulus(1'b1, 64'd0, 6'd0, 6'd63);
    repeat (20) step();
    checkOutput("stall_add_hold", 64'(ram_add),   64'(RSP_DEPTH));
    checkOutput("stall_valid",    64'(rsp_valid), 64'd1);
    checkOutput("stall_busy",     64'(busy),      64'd1);
    randomReady = 1'b1;
    waitIdle(3000);

    // Random SCANs with a randomly stalling consumer.
    repeat (6) begin
      randomizeMem();
      applyStimulus(1'b1, 64'd0, 6'($urandom), 6'($urandom));
      waitIdle(3000);
    end

    // A LOAD offered mid-SCAN must be ignored entirely.
    randomReady = 1'b0;
    rsp_ready   = 1'b0;
    randomizeMem();
    applyStimulus(1'b1, 64'd0, 6'd10, 6'd20);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_data  = {$urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      checkOutput("ignore_wr",    64'(ram_wr),    64'd0);
      checkOutput("ignore_ready", 64'(cmd_ready), 64'd0);
      step();
    end
    cmd_valid = 1'b0;
    checkOutput("ignore_data_kept", ram_data, lastLoad);
    randomReady = 1'b1;
    waitIdle(3000);

`ifdef RAM_SEQ_PARITY_EN
    // Parity of byte 8'h07 with bit 1 is even.
    randomReady = 1'b0;
    rsp_ready   = 1'b0;
    memByte[5]  = 8'h07;
    memBit[5]   = 1'b1;
    applyStimulus(1'b1, 64'd0, 6'd5, 6'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    checkOutput("par_07_valid", 64'(rsp_valid), 64'd1);
    checkOutput("par_07",       64'(rsp_par),   64'd0);
    rsp_ready = 1'b1;
    waitIdle(200);
`endif

    // Reset on the third issuing cycle of a SCAN abandons everything.
    randomReady = 1'b0;
    rsp_ready   = 1'b0;
    applyStimulus(1'b1, 64'd0, 6'd20, 6'd10);
    step();
    step();
    rst = 1'b0;
    expQ.delete();
    step();
    checkResetValues("midscan");
    rst       = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    repeat (12) begin
      step();
      checkOutput("post_rst_valid", 64'(rsp_valid), 64'd0);
      checkOutput("post_rst_busy",  64'(busy),      64'd0);
      n++;
    end

    // Normal operation resumes after the abandoned scan.
    randomizeMem();
    randomReady = 1'b1;
    applyStimulus(1'b1, 64'd0, 6'($urandom), 6'($urandom));
    waitIdle(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_cmd_sequencer.md
RAM_CMD_SEQUENCER -- requirements
Module: ram_cmd_sequencer

Interface
REQ-001 SHALL have parameter RD_LAT, default 2: cycles from ram_add driven to matching ram_byte/ram_bit valid.
REQ-002 SHALL have parameter RSP_DEPTH, default 4: response FIFO entries, power of two.
REQ-003 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port cmd_op  in  1  0 = LOAD word, 1 = SCAN addresses.
REQ-008 SHALL have port cmd_data  in  64  word for LOAD.
REQ-009 SHALL have port cmd_start  in  6  first SCAN address.
REQ-010 SHALL have port cmd_len  in  6  SCAN read count minus 1 (1..64 reads).
REQ-011 SHALL have ports ram_add out 6, ram_data out 64, ram_wr out 1  drive the RAM controller.
REQ-012 SHALL have ports ram_byte in 8, ram_bit in 1  returned RAM controller data.
REQ-013 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_byte out 8, rsp_bit out 1, rsp_last out 1  response stream.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE or reads are in flight.

Function
REQ-015 SHALL implement FSM IDLE, LOAD, ISSUE, DRAIN; cmd_ready = (state==IDLE).
REQ-016 IDLE: accepted cmd_op=0 -> LOAD; accepted cmd_op=1 -> ISSUE, latching start, len, issue counter = 0.
REQ-017 LOAD: ram_data = latched cmd_data, ram_wr = 1 for exactly one cycle, then IDLE; ram_wr = 0 in all other states.
REQ-018 ISSUE: each issuing cycle drives ram_add = (start + issue count) mod 64 and increments count; wrap 63 -> 0 is required.
REQ-019 ISSUE SHALL issue only when in-flight count + FIFO occupancy < RSP_DEPTH; otherwise ram_add holds and no tag is created.
REQ-020 SHALL track each issue with a RD_LAT-deep valid/last tag shift pipeline; tag exit pushes {ram_byte, ram_bit, last} into FIFO.
REQ-021 Last tag SHALL be set on the issue with count == len; FSM then -> DRAIN.
REQ-022 DRAIN -> IDLE when in-flight count == 0 (FIFO may still hold data; draining continues from IDLE).
REQ-023 FIFO: rsp_valid = not empty; pop on rsp_valid & rsp_ready; simultaneous push and pop when full SHALL be legal, occupancy unchanged.
REQ-024 Credit rule (REQ-019) SHALL guarantee no FIFO overflow; push to full FIFO without pop SHALL never occur.
REQ-025 rsp_last SHALL be 1 only on final SCAN response; exactly len+1 responses per SCAN, in address order.
REQ-026 cmd_valid while cmd_ready = 0 SHALL be ignored without side effects.

Reset
REQ-027 rst=0 at a clock edge SHALL force state IDLE, FIFO empty, tag pipeline and counters cleared.
REQ-028 Reset outputs: cmd_ready=1 (after release), ram_add=0, ram_data=0, ram_wr=0, rsp_valid=0, rsp_byte=0, rsp_bit=0, rsp_last=0, busy=0.
REQ-029 Reset mid-SCAN SHALL abandon all in-flight reads; no late push after release.

Configuration
REQ-030 Macro RAM_SEQ_PARITY_EN defined: SHALL add output rsp_par 1 = XOR of rsp_byte[7:0] and rsp_bit, stored per FIFO entry at push.
REQ-031 Macro RAM_SEQ_PARITY_EN undefined: rsp_par port and storage SHALL be absent; all other behaviour identical.

Verification
REQ-032 LOAD cmd_data=64'hA5A5_0000_FFFF_1234 -> ram_wr high exactly 1 cycle with ram_data equal, cmd_ready back high next cycle.
REQ-033 SCAN start=6'd62, len=6'd3, rsp_ready=1 -> ram_add 62,63,0,1 on consecutive cycles; 4 responses, rsp_last only on 4th.
REQ-034 SCAN start=0, len=6'd63, rsp_ready=0 -> exactly 4 issues then stall; release rsp_ready -> all 64 responses, none lost/duplicated.
REQ-035 rst=0 on 3rd ISSUE cycle of SCAN len=10 -> next cycle all REQ-028 values, no rsp_valid after release.
REQ-036 cmd_valid=1 with cmd_op=0 during SCAN -> no ram_wr, command ignored; with RAM_SEQ_PARITY_EN, ram_byte=8'h07, ram_bit=1 -> rsp_par=0.
